inst_trace_stats: RTL and testbench
===================================

// Module: inst_trace_stats
// PURPOSE
//  Consumes the 32-bit fetched-instruction stream that the pipeline top drives to the bench.
//  Classifies each valid MIPS-lite instruction and keeps saturating per-class counters.
//  Detects register dependences (RAW at distance 1 and load-use) to estimate no-forwarding stalls.
//  Freezes on HALT or opr_finished; its counters are the reference numbers for simulator cross-checks.
// PARAMETERS
//  CNT_W   32  width of every counter; all counters saturate at 2**CNT_W-1
//  R0_ZERO 1   1: rs/rt/rd == 0 never create a dependence; 0: R0 treated as an ordinary register
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      synchronous, active-high
//  valid        in   1      inst_in holds a new instruction this cycle
//  opr_finished in   1      run complete; freeze counters
//  inst_in      in   32     instruction: op[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0]
//  total_cnt    out  CNT_W  accepted instructions (all classes, incl. HALT and illegal)
//  arith_cnt    out  CNT_W  ADD ADDI SUB SUBI MUL MULI (op 0x00-0x05)
//  logic_cnt    out  CNT_W  OR ORI AND ANDI XOR XORI (op 0x06-0x0B)
//  mem_cnt      out  CNT_W  LDW STW (0x0C, 0x0D)
//  ctrl_cnt     out  CNT_W  BZ BEQ JR HALT (0x0E-0x11)
//  raw1_cnt     out  CNT_W  instructions reading the dest of the immediately preceding one
//  lduse_cnt    out  CNT_W  subset of raw1 where the producer was LDW
//  illegal      out  1      sticky: op > 0x11 was accepted
//  done         out  1      high in DONE state
// BEHAVIOUR
//  Reset: all counters 0, illegal 0, done 0, prev-dest record invalid, state IDLE.
//  Reset wins over every other input in the same cycle, including mid-run and in DONE.
//  Accept: valid==1 && state!=DONE. Counter updates are visible the cycle after accept.
//  Op decoding:
//   - R-type = even op 0x00-0x0A: sources rs and rt, dest rd.
//   - I-type ALU = odd op 0x01-0x0B, and LDW: source rs, dest rt.
//   - STW and BEQ: sources rs and rt, no dest.
//   - BZ and JR: source rs, no dest.
//   - HALT, illegal: no sources, no dest.
//  Class counters: exactly one of arith/logic/mem/ctrl increments per legal accept.
//   - Illegal op: only total increments; illegal sets.
//  Dependence tracking:
//   - Register prev = {dest valid, dest reg, was_LDW}, loaded on every accept.
//   - A no-dest instruction loads prev as invalid.
//   - raw1 increments if prev valid and any source of the current op == prev dest.
//   - lduse increments additionally if prev was_LDW.
//   - Dependences count once per instruction, even if both rs and rt match.
//   - With R0_ZERO=1, reg 0 never matches.
//   - Cycles with valid==0 do NOT clear prev: distance is in instructions, not cycles.
//  FSM:
//   - IDLE -> RUN on first accept; the IDLE accept is counted like any other.
//   - IDLE/RUN -> DONE on accept of HALT (0x11), or on opr_finished==1.
//   - DONE holds until reset; valid is ignored and counters are frozen.
//   - An instruction accepted in the same cycle as opr_finished is counted, then DONE.
//   - HALT with opr_finished in the same cycle: HALT counted once, DONE next cycle.
//   - done=1 from the cycle after the DONE transition.
//  Saturation: a counter at all-ones stays all-ones; other counters keep counting.
// TESTING
//  1. reset; ADD r3,r1,r2 ; SUB r4,r3,r1 ; HALT (valid every cycle)
//     -> total=3 arith=2 ctrl=1 raw1=1 lduse=0, done=1 one cycle after HALT
//  2. LDW r5,0(r1) ; valid=0 x3 ; ADD r6,r5,r0
//     -> raw1=1 lduse=1, because the bubbles do not break the dependence
//  3. LDW r0,.. ; ADD r1,r0,r0 with R0_ZERO=1 -> raw1=0; same stream with R0_ZERO=0 -> raw1=1
//  4. STW then BEQ reading the previous STW's rt -> raw1=0, because STW has no dest
//  5. inst 0xFC000000 (op 0x3F), then opr_finished in the same cycle as an ORI
//     -> illegal=1 total=2 logic=1, later valid ignored
//  6. CNT_W=4: 17 ADDs -> arith=15 total=15
//     - then reset mid-stream -> all 0, IDLE, done=0 next cycle

Source files
------------

// File: rtl/inst_trace_stats.sv
// Instruction-stream statistics: per-class saturating counters, RAW/load-use
// detection at instruction distance 1, and a freeze on HALT or opr_finished.

module inst_trace_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset)                  cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

module inst_trace_stats #(
  parameter int CNT_W   = 32,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             opr_finished,
  input  logic [31:0]      inst_in,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] arith_cnt,
  output logic [CNT_W-1:0] logic_cnt,
  output logic [CNT_W-1:0] mem_cnt,
  output logic [CNT_W-1:0] ctrl_cnt,
  output logic [CNT_W-1:0] raw1_cnt,
  output logic [CNT_W-1:0] lduse_cnt,
  output logic             illegal,
  output logic             done
);
  localparam int N_CNT = 7;
  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_BZ   = 6'h0E;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
    logic       ld;
  } prev_t;

  state_t state;
  prev_t  prev;

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       accept;
  logic       is_r, is_i, use_rs, use_rt, has_dst, is_ill;
  logic       hit_rs, hit_rt, raw;
  logic [4:0] dst;
  logic [N_CNT-1:0]            inc;
  logic [N_CNT-1:0][CNT_W-1:0] cnt;

  // Immediate/shamt bits below rd carry no information for these statistics.
  logic unused_low;
  assign unused_low = ^inst_in[10:0];

  assign op = inst_in[31:26];
  assign rs = inst_in[25:21];
  assign rt = inst_in[20:16];
  assign rd = inst_in[15:11];

  assign accept = valid && (state != DONE);

  always_comb begin
    is_r    = (op <= 6'h0A) && !op[0];
    is_i    = ((op <= 6'h0B) && op[0]) || (op == OP_LDW);
    use_rs  = is_r || is_i || (op == OP_STW) || (op == OP_BEQ) ||
              (op == OP_BZ) || (op == OP_JR);
    use_rt  = is_r || (op == OP_STW) || (op == OP_BEQ);
    has_dst = is_r || is_i;
    dst     = is_r ? rd : rt;
    is_ill  = op > OP_HALT;
  end

  // A source only matches a live producer; with R0_ZERO, r0 is hard-wired and never matches.
  always_comb begin
    hit_rs = prev.vld && (rs == prev.dst) && !(R0_ZERO && rs == 5'd0);
    hit_rt = prev.vld && (rt == prev.dst) && !(R0_ZERO && rt == 5'd0);
    raw    = (use_rs && hit_rs) || (use_rt && hit_rt);
  end

  always_comb begin
    inc    = '0;
    inc[0] = accept;
    inc[1] = accept && (op <= 6'h05);
    inc[2] = accept && (op >= 6'h06) && (op <= 6'h0B);
    inc[3] = accept && ((op == OP_LDW) || (op == OP_STW));
    inc[4] = accept && (op >= OP_BZ) && (op <= OP_HALT);
    inc[5] = accept && raw;
    inc[6] = accept && raw && prev.ld;
  end

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    inst_trace_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[g]),
      .cnt   (cnt[g])
    );
  end

  assign total_cnt = cnt[0];
  assign arith_cnt = cnt[1];
  assign logic_cnt = cnt[2];
  assign mem_cnt   = cnt[3];
  assign ctrl_cnt  = cnt[4];
  assign raw1_cnt  = cnt[5];
  assign lduse_cnt = cnt[6];

  // Bubbles (valid==0) leave prev untouched so distance is counted in instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      prev.vld <= has_dst;
      prev.dst <= has_dst ? dst : 5'd0;
      prev.ld  <= has_dst && (op == OP_LDW);
      if (is_ill) illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if ((accept && op == OP_HALT) || opr_finished) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (accept) begin
            state <= RUN;
          end
        end
        default: begin
          state <= DONE;
          done  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_trace_stats.sv
// Directed bench for inst_trace_stats: default, R0-as-ordinary and 4-bit-counter builds
// share one stimulus stream; each test checks the build that exercises its point.

module tb_inst_trace_stats;
  logic        clk = 1'b0;
  logic        reset, valid, opr_finished;
  logic [31:0] inst_in;

  logic [31:0] d_total, d_arith, d_logic, d_mem, d_ctrl, d_raw1, d_lduse;
  logic        d_ill, d_done;
  logic [31:0] z_total, z_arith, z_logic, z_mem, z_ctrl, z_raw1, z_lduse;
  logic        z_ill, z_done;
  logic [3:0]  s_total, s_arith, s_logic, s_mem, s_ctrl, s_raw1, s_lduse;
  logic        s_ill, s_done;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_trace_stats u_dut (
    .clk(clk), .reset(reset), .valid(valid), .opr_finished(opr_finished), .inst_in(inst_in),
    .total_cnt(d_total), .arith_cnt(d_arith), .logic_cnt(d_logic), .mem_cnt(d_mem),
    .ctrl_cnt(d_ctrl), .raw1_cnt(d_raw1), .lduse_cnt(d_lduse), .illegal(d_ill), .done(d_done)
  );

  inst_trace_stats #(.R0_ZERO(1'b0)) u_r0 (
    .clk(clk), .reset(reset), .valid(valid), .opr_finished(opr_finished), .inst_in(inst_in),
    .total_cnt(z_total), .arith_cnt(z_arith), .logic_cnt(z_logic), .mem_cnt(z_mem),
    .ctrl_cnt(z_ctrl), .raw1_cnt(z_raw1), .lduse_cnt(z_lduse), .illegal(z_ill), .done(z_done)
  );

  inst_trace_stats #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .valid(valid), .opr_finished(opr_finished), .inst_in(inst_in),
    .total_cnt(s_total), .arith_cnt(s_arith), .logic_cnt(s_logic), .mem_cnt(s_mem),
    .ctrl_cnt(s_ctrl), .raw1_cnt(s_raw1), .lduse_cnt(s_lduse), .illegal(s_ill), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic issue(input logic v, input logic [31:0] i, input logic f);
    valid = v; inst_in = i; opr_finished = f;
    @(posedge clk); #1;
    valid = 1'b0; opr_finished = 1'b0; inst_in = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; valid = 1'b0; opr_finished = 1'b0; inst_in = 32'd0;
    @(posedge clk); #1;

    // reset state, applied while an instruction is offered
    reset = 1'b1; valid = 1'b1; inst_in = rtype(6'h00, 5'd1, 5'd2, 5'd3);
    @(posedge clk); #1;
    reset = 1'b0; valid = 1'b0;
    chk("rst_total", d_total, 0);
    chk("rst_raw1", d_raw1, 0);
    chk("rst_ill", {31'd0, d_ill}, 0);
    chk("rst_done", {31'd0, d_done}, 0);

    // 1: ADD r3,r1,r2 ; SUB r4,r3,r1 ; HALT
    issue(1'b1, rtype(6'h00, 5'd1, 5'd2, 5'd3), 1'b0);
    chk("t1_total_first", d_total, 1);
    issue(1'b1, rtype(6'h02, 5'd3, 5'd1, 5'd4), 1'b0);
    chk("t1_done_pre", {31'd0, d_done}, 0);
    issue(1'b1, itype(6'h11, 5'd0, 5'd0, 16'd0), 1'b0);
    chk("t1_done", {31'd0, d_done}, 1);
    chk("t1_total", d_total, 3);
    chk("t1_arith", d_arith, 2);
    chk("t1_ctrl", d_ctrl, 1);
    chk("t1_raw1", d_raw1, 1);
    chk("t1_lduse", d_lduse, 0);
    issue(1'b1, rtype(6'h00, 5'd4, 5'd4, 5'd5), 1'b0);
    chk("t1_frozen", d_total, 3);
    chk("t1_frozen_raw", d_raw1, 1);

    // 2: LDW r5,0(r1) ; 3 bubbles ; ADD r6,r5,r0
    do_reset();
    chk("t2_rst_from_done", {31'd0, d_done}, 0);
    chk("t2_rst_total", d_total, 0);
    issue(1'b1, itype(6'h0C, 5'd1, 5'd5, 16'd0), 1'b0);
    for (int k = 0; k < 3; k++) issue(1'b0, 32'hFFFF_FFFF, 1'b0);
    issue(1'b1, rtype(6'h00, 5'd5, 5'd0, 5'd6), 1'b0);
    chk("t2_total", d_total, 2);
    chk("t2_mem", d_mem, 1);
    chk("t2_raw1", d_raw1, 1);
    chk("t2_lduse", d_lduse, 1);

    // 3: LDW r0 ; ADD r1,r0,r0 under both R0 policies
    do_reset();
    issue(1'b1, itype(6'h0C, 5'd2, 5'd0, 16'd4), 1'b0);
    issue(1'b1, rtype(6'h00, 5'd0, 5'd0, 5'd1), 1'b0);
    chk("t3_r0zero_raw1", d_raw1, 0);
    chk("t3_r0zero_lduse", d_lduse, 0);
    chk("t3_r0reg_raw1", z_raw1, 1);
    chk("t3_r0reg_lduse", z_lduse, 1);

    // 4: STW r2,0(r1) ; BEQ r3,r2 -- STW writes nothing
    do_reset();
    issue(1'b1, itype(6'h0D, 5'd1, 5'd2, 16'd0), 1'b0);
    issue(1'b1, itype(6'h0F, 5'd3, 5'd2, 16'd8), 1'b0);
    chk("t4_raw1", d_raw1, 0);
    chk("t4_mem", d_mem, 1);
    chk("t4_ctrl", d_ctrl, 1);

    // 4b: ORI r7 ; XOR r8,r1,r7 ; AND r9,r8,r8 (both sources match, counted once)
    do_reset();
    issue(1'b1, itype(6'h07, 5'd1, 5'd7, 16'h00FF), 1'b0);
    issue(1'b1, rtype(6'h0A, 5'd1, 5'd7, 5'd8), 1'b0);
    issue(1'b1, rtype(6'h08, 5'd8, 5'd8, 5'd9), 1'b0);
    chk("t4b_logic", d_logic, 3);
    chk("t4b_raw1", d_raw1, 2);
    chk("t4b_lduse", d_lduse, 0);

    // 5: illegal op 0x3F, then ORI together with opr_finished
    do_reset();
    issue(1'b1, 32'hFC00_0000, 1'b0);
    chk("t5_ill", {31'd0, d_ill}, 1);
    chk("t5_done_pre", {31'd0, d_done}, 0);
    issue(1'b1, itype(6'h07, 5'd1, 5'd2, 16'd1), 1'b1);
    chk("t5_done", {31'd0, d_done}, 1);
    chk("t5_total", d_total, 2);
    chk("t5_logic", d_logic, 1);
    chk("t5_arith", d_arith, 0);
    issue(1'b1, rtype(6'h00, 5'd1, 5'd2, 5'd3), 1'b0);
    chk("t5_ignored", d_total, 2);

    // 5b: HALT together with opr_finished counts once
    do_reset();
    issue(1'b1, itype(6'h11, 5'd0, 5'd0, 16'd0), 1'b1);
    issue(1'b1, itype(6'h11, 5'd0, 5'd0, 16'd0), 1'b0);
    chk("t5b_total", d_total, 1);
    chk("t5b_ctrl", d_ctrl, 1);
    chk("t5b_done", {31'd0, d_done}, 1);

    // 6: 17 ADDs -> 4-bit counters stick at 15, wide counters keep going
    do_reset();
    for (int k = 0; k < 17; k++) issue(1'b1, rtype(6'h00, 5'd1, 5'd2, 5'd3), 1'b0);
    chk("t6_sat_arith", {28'd0, s_arith}, 15);
    chk("t6_sat_total", {28'd0, s_total}, 15);
    chk("t6_sat_logic", {28'd0, s_logic}, 0);
    chk("t6_wide_arith", d_arith, 17);
    reset = 1'b1; valid = 1'b1; inst_in = rtype(6'h00, 5'd1, 5'd2, 5'd3);
    @(posedge clk); #1;
    reset = 1'b0; valid = 1'b0;
    chk("t6_rst_total", {28'd0, s_total}, 0);
    chk("t6_rst_arith", {28'd0, s_arith}, 0);
    chk("t6_rst_done", {31'd0, s_done}, 0);
    issue(1'b1, rtype(6'h00, 5'd1, 5'd2, 5'd3), 1'b0);
    chk("t6_restart", {28'd0, s_total}, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
